hazard_bypass_control: RTL

Pipeline interlock and forwarding controller for the 5-stage stall/bypass core.
- Keeps a three-entry shadow scoreboard of destination registers in flight in execute, memory and writeback.
- From it, generates the `rs1_data_bypass` / `rs2_data_bypass` selects consumed by the decode unit's operand muxes.
- Generates the load-use stall that holds fetch/decode and injects a bubble into execute.
- Sits beside decode; the only state is the scoreboard (plus optional statistics counters).

---
 rtl/hazard_bypass_control.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_bypass_control.sv
// hazard_bypass_control
// Interlock and forwarding controller that sits beside decode. A three-entry
// shadow scoreboard (EX, MEM, WB) tracks destination registers in flight and
// drives the operand bypass selects plus the load-use stall/bubble.
// Optional feature: define HAZARD_STATS_EN to add the stall_cycles and
// bypass_events 32-bit statistics counters and their output ports.
//
// Handshake note: there is no valid/ready pair here. decode presents an
// instruction with dec_valid; it is accepted into EX on a rising edge only when
// hold=0, stall=0 and flush=0. hold freezes the whole scoreboard.
module hazard_bypass_control #(
    parameter int CORE         = 0,
    parameter int REG_SEL_BITS = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    dec_valid,
    input  logic [REG_SEL_BITS-1:0] dec_rs1,
    input  logic [REG_SEL_BITS-1:0] dec_rs2,
    input  logic                    dec_rs1_used,
    input  logic                    dec_rs2_used,
    input  logic [REG_SEL_BITS-1:0] dec_rd,
    input  logic                    dec_reg_write,
    input  logic                    dec_mem_read,
    input  logic                    report,
    output logic [1:0]              rs1_data_bypass,
    output logic [1:0]              rs2_data_bypass,
    output logic                    stall,
    output logic                    bubble
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             bypass_events
`endif
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // Scoreboard entries. "live" already folds in valid, reg_write and rd != 0,
    // so an entry either participates in matching or it does not.
    logic                    ex_live_q,  ex_live_d;
    logic [REG_SEL_BITS-1:0] ex_rd_q,    ex_rd_d;
    logic                    ex_ld_q,    ex_ld_d;
    logic                    mem_live_q, mem_live_d;
    logic [REG_SEL_BITS-1:0] mem_rd_q,   mem_rd_d;
    logic                    mem_ld_q,   mem_ld_d;
    logic                    wb_live_q,  wb_live_d;
    logic [REG_SEL_BITS-1:0] wb_rd_q,    wb_rd_d;
    logic                    wb_ld_q,    wb_ld_d;

    logic rs1_live, rs2_live;
    logic rs1_ex, rs1_mem, rs1_wb;
    logic rs2_ex, rs2_mem, rs2_wb;
    logic load_use;
    logic sel_ok;
    logic issue;
    logic [1:0] rs1_sel, rs2_sel;

    // Report printing belongs to simulation wrappers; these inputs are only
    // kept referenced here.
    logic unused_report;
    assign unused_report = report ^ CORE[0];

    // Source-to-entry matches; x0 and unread sources never match.
    always_comb begin
        rs1_live = dec_rs1_used && (dec_rs1 != '0);
        rs2_live = dec_rs2_used && (dec_rs2 != '0);
        rs1_ex   = rs1_live && ex_live_q  && (ex_rd_q  == dec_rs1);
        rs1_mem  = rs1_live && mem_live_q && (mem_rd_q == dec_rs1);
        rs1_wb   = rs1_live && wb_live_q  && (wb_rd_q  == dec_rs1);
        rs2_ex   = rs2_live && ex_live_q  && (ex_rd_q  == dec_rs2);
        rs2_mem  = rs2_live && mem_live_q && (mem_rd_q == dec_rs2);
        rs2_wb   = rs2_live && wb_live_q  && (wb_rd_q  == dec_rs2);
    end

    // A load still in EX or MEM cannot forward yet; flush overrides the stall
    // because the dependent instruction is being killed anyway.
    assign load_use = dec_valid &&
                      (((rs1_ex  || rs2_ex)  && ex_ld_q) ||
                       ((rs1_mem || rs2_mem) && mem_ld_q));
    assign stall    = load_use && !flush;
    assign bubble   = stall;
    assign sel_ok   = dec_valid && !flush && !load_use;
    assign issue    = dec_valid && !stall && !flush;

    // Youngest producer wins: EX, then MEM, then WB (WB also covers loads).
    always_comb begin
        rs1_sel = SEL_RF;
        rs2_sel = SEL_RF;
        if (sel_ok) begin
            if (rs1_ex)       rs1_sel = SEL_EX;
            else if (rs1_mem) rs1_sel = SEL_MEM;
            else if (rs1_wb)  rs1_sel = SEL_WB;
            if (rs2_ex)       rs2_sel = SEL_EX;
            else if (rs2_mem) rs2_sel = SEL_MEM;
            else if (rs2_wb)  rs2_sel = SEL_WB;
        end
    end

    assign rs1_data_bypass = rs1_sel;
    assign rs2_data_bypass = rs2_sel;

    // Scoreboard advance: shift toward WB and admit the decode instruction
    // into EX, or a bubble when it is stalled, flushed or absent.
    always_comb begin
        ex_live_d  = ex_live_q;
        ex_rd_d    = ex_rd_q;
        ex_ld_d    = ex_ld_q;
        mem_live_d = mem_live_q;
        mem_rd_d   = mem_rd_q;
        mem_ld_d   = mem_ld_q;
        wb_live_d  = wb_live_q;
        wb_rd_d    = wb_rd_q;
        wb_ld_d    = wb_ld_q;
        if (!hold) begin
            wb_live_d  = mem_live_q;
            wb_rd_d    = mem_rd_q;
            wb_ld_d    = mem_ld_q;
            mem_live_d = ex_live_q;
            mem_rd_d   = ex_rd_q;
            mem_ld_d   = ex_ld_q;
            ex_live_d  = issue && dec_reg_write && (dec_rd != '0);
            ex_rd_d    = dec_rd;
            ex_ld_d    = dec_mem_read;
        end
    end

    // Scoreboard state registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_live_q  <= 1'b0;
            ex_rd_q    <= '0;
            ex_ld_q    <= 1'b0;
            mem_live_q <= 1'b0;
            mem_rd_q   <= '0;
            mem_ld_q   <= 1'b0;
            wb_live_q  <= 1'b0;
            wb_rd_q    <= '0;
            wb_ld_q    <= 1'b0;
        end else begin
            ex_live_q  <= ex_live_d;
            ex_rd_q    <= ex_rd_d;
            ex_ld_q    <= ex_ld_d;
            mem_live_q <= mem_live_d;
            mem_rd_q   <= mem_rd_d;
            mem_ld_q   <= mem_ld_d;
            wb_live_q  <= wb_live_d;
            wb_rd_q    <= wb_rd_d;
            wb_ld_q    <= wb_ld_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bypass_cnt_q, bypass_cnt_d;
    logic [1:0]  n_byp;

    assign n_byp = {1'b0, |rs1_sel} + {1'b0, |rs2_sel};

    // Counters only move on cycles where the pipeline actually advances.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bypass_cnt_d = bypass_cnt_q;
        if (!hold) begin
            stall_cnt_d  = stall_cnt_q + {31'd0, stall};
            bypass_cnt_d = bypass_cnt_q + {30'd0, n_byp};
        end
    end

    // Statistics registers, wrap-around, cleared with the scoreboard.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bypass_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bypass_cnt_q <= bypass_cnt_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign bypass_events = bypass_cnt_q;
`endif

endmodule
